// File: rtl/rs_test_pkg.sv
// Shared constants for the Reed-Solomon link test bench sources.
// PRBS tap masks are Fibonacci-style: bit k set means state[k] feeds the XOR.
package rs_test_pkg;

  localparam logic [6:0]  PRBS7_TAPS       = 7'h60;      // x^7  + x^6  + 1
  localparam logic [14:0] PRBS15_TAPS      = 15'h6000;   // x^15 + x^14 + 1
  localparam logic [22:0] PRBS23_TAPS      = 23'h420000; // x^23 + x^18 + 1
  localparam logic [14:0] DEFAULT_SEED     = 15'h0001;
  localparam int          DEFAULT_SYM_W    = 4;
  localparam int          DEFAULT_DIV_HALF = 4;

endpackage

// File: rtl/bit_clk_divider.sv
// Slow bit-clock generator with a prime cycle and a falling-edge advance strobe.
// o_advance is combinational so the LFSR advances in the same cycle the clock falls.
module bit_clk_divider #(
  parameter int DIV_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_clk,
  output logic o_advance
);

  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_bit_clk;
  logic          r_prime;
  logic          w_wrap;

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign o_bit_clk = r_bit_clk;

  // Advance on the prime cycle or on a high-to-low toggle; clear always wins.
  assign o_advance = i_en & ~i_clear & (r_prime | (w_wrap & r_bit_clk));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_clk <= 1'b0;
      r_prime   <= 1'b1;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_bit_clk <= 1'b0;
      r_prime   <= 1'b1;
    end else if (i_en) begin
      if (r_prime) begin
        r_prime <= 1'b0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_bit_clk <= ~r_bit_clk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prbs_bit_source.sv
// PRBS bit source: Fibonacci LFSR clocked by a slow bit clock, plus a symbol packer.
// o_dbg_state exposes the LFSR state for checkers and bring-up.
module prbs_bit_source
  import rs_test_pkg::*;
#(
  parameter int                DIV_HALF = DEFAULT_DIV_HALF,
  parameter int                LFSR_W   = 15,
  parameter logic [LFSR_W-1:0] TAPS     = PRBS15_TAPS,
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
  parameter int                SYM_W    = DEFAULT_SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_seed,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              bit_out,
  output logic              bit_clk_out,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_valid,
  output logic [LFSR_W-1:0] o_dbg_state
);

  localparam int PCW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam logic [PCW-1:0] PACK_LAST = PCW'(SYM_W - 1);

  logic [LFSR_W-1:0] r_state;
  logic              r_bit;
  logic [SYM_W-1:0]  r_shift;
  logic [SYM_W-1:0]  r_sym;
  logic              r_sym_valid;
  logic [PCW-1:0]    r_pack_cnt;

  logic              w_advance;
  logic              w_fb;
  logic [SYM_W-1:0]  w_sym_next;

  bit_clk_divider #(
    .DIV_HALF (DIV_HALF)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_en      (en),
    .i_clear   (load_seed),
    .o_bit_clk (bit_clk_out),
    .o_advance (w_advance)
  );

  assign w_fb       = ^(r_state & TAPS);
  assign w_sym_next = {r_shift[SYM_W-2:0], w_fb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEED;
      r_bit       <= 1'b0;
      r_shift     <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_pack_cnt  <= '0;
    end else begin
      r_sym_valid <= 1'b0;
      if (load_seed) begin
        // An all-zero seed would lock the LFSR, so it is replaced by 1.
        r_state    <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
        r_shift    <= '0;
        r_pack_cnt <= '0;
      end else if (w_advance) begin
        r_state <= {r_state[LFSR_W-2:0], w_fb};
        r_bit   <= w_fb;
        r_shift <= w_sym_next;
        if (r_pack_cnt == PACK_LAST) begin
          r_sym       <= w_sym_next;
          r_sym_valid <= 1'b1;
          r_pack_cnt  <= '0;
        end else begin
          r_pack_cnt <= r_pack_cnt + 1'b1;
        end
      end
    end
  end

  assign bit_out     = r_bit;
  assign sym_out     = r_sym;
  assign sym_valid   = r_sym_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prbs_bit_source.sv
// Directed bench for prbs_bit_source: PRBS-15 default instance plus a PRBS-7 instance
// used to walk a complete sequence period within a short run.
module tb_prbs_bit_source;
  import rs_test_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_seed;
  logic [14:0] seed_in;
  logic        bit_out;
  logic        bit_clk_out;
  logic [3:0]  sym_out;
  logic        sym_valid;
  logic [14:0] dbg_state;

  logic        en7;
  logic [6:0]  seed7;
  logic        bit7;
  logic        bclk7;
  logic [3:0]  sym7;
  logic        sv7;
  logic [6:0]  dbg7;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs_bit_source #(
    .DIV_HALF (4), .LFSR_W (15), .TAPS (15'h6000), .SEED (15'h0001), .SYM_W (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_seed   (load_seed),
    .seed_in     (seed_in),
    .bit_out     (bit_out),
    .bit_clk_out (bit_clk_out),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .o_dbg_state (dbg_state)
  );

  prbs_bit_source #(
    .DIV_HALF (2), .LFSR_W (7), .TAPS (PRBS7_TAPS), .SEED (7'h01), .SYM_W (4)
  ) u_p7 (
    .clk         (clk),
    .rst         (rst),
    .en          (en7),
    .load_seed   (1'b0),
    .seed_in     (seed7),
    .bit_out     (bit7),
    .bit_clk_out (bclk7),
    .sym_out     (sym7),
    .sym_valid   (sv7),
    .o_dbg_state (dbg7)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // x^15 + x^14 + 1, written straight from the polynomial.
  function automatic logic [14:0] next15(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load_seed = 1'b0; seed_in = '0; en7 = 1'b0; seed7 = '0;
    repeat (3) step();
    checks++; if (bit_out !== 1'b0)     begin failures++; $display("FAIL reset_bit: got %b expected 0", bit_out); end
    checks++; if (bit_clk_out !== 1'b0) begin failures++; $display("FAIL reset_bclk: got %b expected 0", bit_clk_out); end
    checks++; if (sym_out !== 4'h0)     begin failures++; $display("FAIL reset_sym: got %h expected 0", sym_out); end
    checks++; if (sym_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b expected 0", sym_valid); end
    checks++; if (dbg_state !== 15'h0001) begin failures++; $display("FAIL reset_state: got %h expected 0001", dbg_state); end
  endtask

  task automatic test_startup();
    logic [0:15] eb;
    logic [3:0]  es [4];
    logic        prev;
    int          nr, ns;
    eb = 16'b0000_0000_0000_0110;
    es = '{4'h0, 4'h0, 4'h0, 4'h6};
    nr = 0; ns = 0;
    prev = bit_clk_out;
    rst = 1'b0;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      step();
      if (bit_clk_out && !prev) begin
        checks++;
        if (cyc != 5 + 8 * nr) begin failures++; $display("FAIL startup_rise_time: got cycle %0d expected %0d", cyc, 5 + 8 * nr); end
        if (nr < 16) begin
          checks++;
          if (bit_out !== eb[nr]) begin failures++; $display("FAIL startup_bit%0d: got %b expected %b", nr + 1, bit_out, eb[nr]); end
        end
        nr++;
      end
      if (sym_valid) begin
        checks++;
        if (cyc != 25 + 32 * ns || ns >= 4) begin
          failures++; $display("FAIL startup_sym_time: got cycle %0d expected %0d", cyc, 25 + 32 * ns);
        end else if (sym_out !== es[ns]) begin
          failures++; $display("FAIL startup_sym%0d: got %h expected %h", ns, sym_out, es[ns]);
        end
        ns++;
      end
      prev = bit_clk_out;
    end
    checks++; if (nr != 16) begin failures++; $display("FAIL startup_rise_count: got %0d expected 16", nr); end
    checks++; if (ns != 4)  begin failures++; $display("FAIL startup_sym_count: got %0d expected 4", ns); end
  endtask

  task automatic test_sequence();
    logic [14:0] m;
    logic        prev, got;
    m = 15'h0001;
    repeat (16) m = next15(m);
    checks++; if (dbg_state !== m) begin failures++; $display("FAIL seq_state16: got %h expected %h", dbg_state, m); end
    for (int b = 0; b < 200; b++) begin
      got = 1'b0;
      for (int k = 0; k < 16 && !got; k++) begin
        prev = bit_clk_out;
        step();
        if (bit_clk_out && !prev) got = 1'b1;
      end
      m = next15(m);
      checks++;
      if (!got || bit_out !== m[0] || dbg_state !== m || dbg_state == '0) begin
        failures++;
        $display("FAIL seq_bit%0d: got rise=%b bit=%b state=%h expected bit=%b state=%h", b + 17, got, bit_out, dbg_state, m[0], m);
      end
    end
  endtask

  task automatic test_load_seed();
    logic [14:0] seeds [2];
    logic [14:0] exp_st [2];
    logic [3:0]  exp_b4 [2];
    logic        held, prev;
    int          nr, ns;
    seeds  = '{15'h0000, 15'h4000};
    exp_st = '{15'h0001, 15'h4000};
    exp_b4 = '{4'b0000, 4'b1000};
    for (int v = 0; v < 2; v++) begin
      held = bit_out;
      load_seed = 1'b1; seed_in = seeds[v];
      step();
      load_seed = 1'b0;
      checks++;
      if (dbg_state !== exp_st[v] || bit_clk_out !== 1'b0 || sym_valid !== 1'b0 || bit_out !== held) begin
        failures++;
        $display("FAIL load%0d_immediate: got state=%h bclk=%b valid=%b bit=%b expected state=%h bclk=0 valid=0 bit=%b",
                 v, dbg_state, bit_clk_out, sym_valid, bit_out, exp_st[v], held);
      end
      nr = 0; ns = 0; prev = bit_clk_out;
      for (int cyc = 1; cyc <= 32; cyc++) begin
        step();
        if (bit_clk_out && !prev) begin
          checks++;
          if (cyc != 5 + 8 * nr || bit_out !== exp_b4[v][3 - nr]) begin
            failures++;
            $display("FAIL load%0d_rise%0d: got cycle %0d bit %b expected cycle %0d bit %b", v, nr, cyc, bit_out, 5 + 8 * nr, exp_b4[v][3 - nr]);
          end
          nr++;
        end
        if (sym_valid) begin
          checks++;
          if (cyc != 25 || sym_out !== exp_b4[v]) begin
            failures++;
            $display("FAIL load%0d_sym: got cycle %0d sym %h expected cycle 25 sym %h", v, cyc, sym_out, exp_b4[v]);
          end
          ns++;
        end
        prev = bit_clk_out;
      end
      checks++; if (nr != 4 || ns != 1) begin failures++; $display("FAIL load%0d_counts: got rises=%0d syms=%0d expected 4 and 1", v, nr, ns); end
    end
  endtask

  task automatic test_en_freeze();
    logic        prev, got;
    logic        b0;
    logic [14:0] s0;
    logic [3:0]  y0;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      prev = bit_clk_out;
      step();
      if (bit_clk_out && !prev) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL freeze_wait_rise: got no rise expected one within 16 cycles"); end
    step();
    en = 1'b0;
    b0 = bit_out; s0 = dbg_state; y0 = sym_out;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (bit_clk_out !== 1'b1 || bit_out !== b0 || dbg_state !== s0 || sym_out !== y0 || sym_valid !== 1'b0) begin
        failures++;
        $display("FAIL freeze_hold%0d: got bclk=%b bit=%b state=%h sym=%h valid=%b expected bclk=1 bit=%b state=%h sym=%h valid=0",
                 k, bit_clk_out, bit_out, dbg_state, sym_out, sym_valid, b0, s0, y0);
      end
    end
    en = 1'b1;
    step(); step();
    checks++; if (bit_clk_out !== 1'b1 || dbg_state !== s0) begin failures++; $display("FAIL freeze_high_rest: got bclk=%b state=%h expected bclk=1 state=%h", bit_clk_out, dbg_state, s0); end
    step();
    checks++;
    if (bit_clk_out !== 1'b0 || dbg_state !== next15(s0) || bit_out !== next15(s0)[0]) begin
      failures++;
      $display("FAIL freeze_resume_fall: got bclk=%b state=%h bit=%b expected bclk=0 state=%h bit=%b",
               bit_clk_out, dbg_state, bit_out, next15(s0), next15(s0)[0]);
    end
  endtask

  task automatic test_rst_mid();
    logic prev, got;
    int   rise_cyc;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      prev = bit_clk_out;
      step();
      if (bit_clk_out && !prev) got = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!got || bit_clk_out !== 1'b0 || bit_out !== 1'b0 || sym_out !== 4'h0 || sym_valid !== 1'b0 || dbg_state !== 15'h0001) begin
      failures++;
      $display("FAIL rst_mid_immediate: got rise=%b bclk=%b bit=%b sym=%h valid=%b state=%h expected all reset values",
               got, bit_clk_out, bit_out, sym_out, sym_valid, dbg_state);
    end
    step(); step();
    rst = 1'b0;
    rise_cyc = 0; prev = bit_clk_out;
    for (int cyc = 1; cyc <= 8 && rise_cyc == 0; cyc++) begin
      step();
      if (bit_clk_out && !prev) rise_cyc = cyc;
      prev = bit_clk_out;
    end
    checks++; if (rise_cyc != 5 || bit_out !== 1'b0) begin failures++; $display("FAIL rst_mid_restart: got rise cycle %0d bit %b expected cycle 5 bit 0", rise_cyc, bit_out); end
  endtask

  task automatic test_prbs7_period();
    logic [6:0] s0;
    logic       b0, prev, got, zero_seen;
    int         ones, ret;
    ones = 0; ret = 0; zero_seen = 1'b0; s0 = '0; b0 = 1'b0;
    en7 = 1'b1;
    for (int r = 0; r <= 127; r++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        prev = bclk7;
        step();
        if (bclk7 && !prev) got = 1'b1;
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL p7_rise%0d: got no rise expected one within 8 cycles", r);
        break;
      end
      if (r == 0) begin
        s0 = dbg7; b0 = bit7;
      end else if (dbg7 == s0 && ret == 0) begin
        ret = r;
      end
      if (r < 127) ones += int'(bit7);
      if (dbg7 == '0) zero_seen = 1'b1;
    end
    checks++; if (ret != 127) begin failures++; $display("FAIL p7_period: got %0d expected 127", ret); end
    checks++; if (ones != 64) begin failures++; $display("FAIL p7_ones: got %0d expected 64", ones); end
    checks++; if (zero_seen)  begin failures++; $display("FAIL p7_zero_state: got seen expected never"); end
    checks++; if (bit7 !== b0) begin failures++; $display("FAIL p7_repeat_bit: got %b expected %b", bit7, b0); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_sequence();
    test_load_seed();
    test_en_freeze();
    test_rst_mid();
    test_prbs7_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
